// File: rtl/jt12_i2s_tx.sv
// I2S transmitter for signed 12-bit stereo samples: one-deep pending buffer,
// frame repeat on starvation, overrun pulse when a pending pair is overwritten.
module jt12_i2s_tx #(
    parameter int DIV  = 1,
    parameter int SLOT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [11:0] left,
    input  logic [11:0] right,
    input  logic        sample_strobe,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata,
    output logic        overrun
);

    localparam int FW = 2 * SLOT;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(FW);

    // Handshake: sample_strobe is a one-cycle valid qualified by clk_en; there is
    // no ready, the block always accepts and flags overrun if a pair is lost.

    logic [CW-1:0] div_cnt, div_cnt_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt, bit_inc;
    logic          bclk_nxt, lrck_nxt, sdata_nxt, overrun_nxt;
    logic [FW-1:0] shreg, shreg_nxt, load_word;
    logic [11:0]   pend_l, pend_r, pend_l_nxt, pend_r_nxt;
    logic [11:0]   last_l, last_r, last_l_nxt, last_r_nxt;
    logic [11:0]   load_l, load_r;
    logic          pend_valid, pend_valid_nxt;
    logic          div_wrap, fall, frame_load, capture;

    function automatic logic [SLOT-1:0] slot_word(input logic [11:0] s);
        slot_word = SLOT'(s) << (SLOT - 12);
    endfunction

    always_comb begin
        div_wrap   = clk_en && (div_cnt == CW'(DIV - 1));
        fall       = div_wrap && bclk;
        frame_load = fall && (bit_cnt == BW'(FW - 1));
        capture    = clk_en && sample_strobe;
        bit_inc    = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + 1'b1;
        load_l     = pend_valid ? pend_l : last_l;
        load_r     = pend_valid ? pend_r : last_r;
        load_word  = {slot_word(load_l), slot_word(load_r)};
    end

    always_comb begin
        div_cnt_nxt    = div_cnt;
        bclk_nxt       = bclk;
        bit_cnt_nxt    = bit_cnt;
        lrck_nxt       = lrck;
        sdata_nxt      = sdata;
        shreg_nxt      = shreg;
        pend_l_nxt     = pend_l;
        pend_r_nxt     = pend_r;
        pend_valid_nxt = pend_valid;
        last_l_nxt     = last_l;
        last_r_nxt     = last_r;
        overrun_nxt    = 1'b0;

        if (clk_en) begin
            div_cnt_nxt = div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk_nxt = ~bclk;
            end
        end

        // The MSB shifted out at the wrap is the previous frame's right LSB,
        // which gives the one-bit I2S delay without a separate pipeline stage.
        if (fall) begin
            bit_cnt_nxt = bit_inc;
            lrck_nxt    = (bit_inc >= BW'(SLOT));
            sdata_nxt   = shreg[FW-1];
            shreg_nxt   = frame_load ? load_word : (shreg << 1);
        end

        if (frame_load) begin
            last_l_nxt     = load_l;
            last_r_nxt     = load_r;
            pend_valid_nxt = 1'b0;
        end

        if (capture) begin
            pend_l_nxt     = left;
            pend_r_nxt     = right;
            pend_valid_nxt = 1'b1;
            overrun_nxt    = pend_valid && !frame_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= '0;
            lrck       <= 1'b0;
            sdata      <= 1'b0;
            shreg      <= '0;
            pend_l     <= '0;
            pend_r     <= '0;
            pend_valid <= 1'b0;
            last_l     <= '0;
            last_r     <= '0;
            overrun    <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_nxt;
            bclk       <= bclk_nxt;
            bit_cnt    <= bit_cnt_nxt;
            lrck       <= lrck_nxt;
            sdata      <= sdata_nxt;
            shreg      <= shreg_nxt;
            pend_l     <= pend_l_nxt;
            pend_r     <= pend_r_nxt;
            pend_valid <= pend_valid_nxt;
            last_l     <= last_l_nxt;
            last_r     <= last_r_nxt;
            overrun    <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Bench for jt12_i2s_tx: two instances (DIV=1/SLOT=16 and DIV=3/SLOT=12) share
// stimulus; frames are deserialised from the pins and checked against a tick-count model.
module tb_jt12_i2s_tx;

    localparam int F0 = 4 * 1 * 16;  // clk_en ticks per frame of instance 0

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en0    = 1'b1;
    logic        en1    = 1'b0;
    logic        strobe = 1'b0;
    logic [11:0] left   = '0;
    logic [11:0] right  = '0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        en1 = ~en1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D  = (g == 0) ? 1 : 3;
        localparam int S  = (g == 0) ? 16 : 12;
        localparam int FT = 4 * D * S;

        logic en, bclk, lrck, sdata, overrun;
        assign en = (g == 0) ? en0 : en1;

        jt12_i2s_tx #(.DIV(D), .SLOT(S)) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .clk_en        (en),
            .left          (left),
            .right         (right),
            .sample_strobe (strobe),
            .bclk          (bclk),
            .lrck          (lrck),
            .sdata         (sdata),
            .overrun       (overrun)
        );

        // Reference model: frame boundaries are every FT enabled ticks,
        // bclk level is (ticks / DIV) mod 2.
        int          m_tick = 0;
        logic        m_pv = 1'b0;
        logic        load;
        logic [23:0] m_pend = '0;
        logic [23:0] m_last = '0;
        logic        exp_bclk = 1'b0;
        logic        exp_ovr = 1'b0;
        logic [23:0] exp_q[$];

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_tick   = 0;
                m_pv     = 1'b0;
                m_pend   = '0;
                m_last   = '0;
                exp_ovr  = 1'b0;
                exp_bclk = 1'b0;
                exp_q.delete();
                exp_q.push_back('0);
            end else begin
                exp_ovr = 1'b0;
                if (en) begin
                    m_tick++;
                    load = (m_tick % FT) == 0;
                    if (load) begin
                        if (m_pv) begin
                            m_last = m_pend;
                            m_pv   = 1'b0;
                        end
                        exp_q.push_back(m_last);
                    end
                    if (strobe) begin
                        exp_ovr = m_pv && !load;
                        m_pend  = {left, right};
                        m_pv    = 1'b1;
                    end
                    exp_bclk = ((m_tick / D) % 2) == 1;
                end
            end
        end

        // Monitor: track bit position from bclk falls, sample on rises.
        int            p = 0;
        int            frames = 0;
        logic          prev_bclk = 1'b0;
        logic          started = 1'b0;
        logic [2*S-1:0] acc = '0;
        logic [2*S-1:0] exp_w;
        logic [S-1:0]  wl, wr;
        logic [23:0]   pair;

        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                p         = 0;
                prev_bclk = 1'b0;
                started   = 1'b0;
                acc       = '0;
            end else begin
                check($sformatf("i%0d_bclk", g), 64'(bclk), 64'(exp_bclk));
                check($sformatf("i%0d_overrun", g), 64'(overrun), 64'(exp_ovr));
                if (prev_bclk && !bclk) p = (p + 1) % (2 * S);
                if (!prev_bclk && bclk) begin
                    check($sformatf("i%0d_lrck_p%0d", g, p), 64'(lrck), 64'(p >= S));
                    if (p == 0) begin
                        if (started) begin
                            acc[0] = sdata;
                            if (exp_q.size() == 0) begin
                                n_tests++;
                                n_fail++;
                                $display("FAIL i%0d_frame: got %0h expected none queued", g, acc);
                            end else begin
                                pair  = exp_q.pop_front();
                                wl    = S'(pair[23:12]) << (S - 12);
                                wr    = S'(pair[11:0]) << (S - 12);
                                exp_w = {wl, wr};
                                check($sformatf("i%0d_frame%0d", g, frames), 64'(acc), 64'(exp_w));
                                frames++;
                            end
                        end
                        started = 1'b1;
                        acc     = '0;
                    end else begin
                        acc[2*S-p] = sdata;
                    end
                end
                prev_bclk = bclk;
            end
        end
    end

    task automatic pulse(input logic [11:0] l, input logic [11:0] r);
        left   = l;
        right  = r;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    // Wait (at a negedge) until instance 0 has completed ph ticks into its frame.
    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while ((g_inst[0].m_tick % F0) != ph && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_phase%0d: got timeout expected phase reached", ph);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en0   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // basic frame
        wait_phase(20);
        pulse(12'h5A3, 12'hA5C);

        // repeat: one pair, then three starved frames
        wait_phase(20);
        pulse(12'h7FF, 12'h800);
        repeat (3) begin
            @(negedge clk);
            wait_phase(20);
        end

        // overrun: two strobes in one frame
        wait_phase(10);
        pulse(12'h001, 12'h001);
        repeat (5) @(negedge clk);
        pulse(12'h002, 12'h002);

        // strobe coinciding with the frame load
        wait_phase(10);
        pulse(12'h111, 12'h111);
        wait_phase(F0 - 1);
        pulse(12'h222, 12'h222);
        repeat (2 * F0 + 2) @(negedge clk);

        // async reset mid-frame while instance 0 has bclk high
        wait_phase(41);
        #1 rst_n = 1'b0;
        #1;
        check("rst_i0_bclk", 64'(g_inst[0].bclk), 64'd0);
        check("rst_i0_lrck", 64'(g_inst[0].lrck), 64'd0);
        check("rst_i0_sdata", 64'(g_inst[0].sdata), 64'd0);
        check("rst_i0_overrun", 64'(g_inst[0].overrun), 64'd0);
        check("rst_i1_bclk", 64'(g_inst[1].bclk), 64'd0);
        check("rst_i1_lrck", 64'(g_inst[1].lrck), 64'd0);
        check("rst_i1_sdata", 64'(g_inst[1].sdata), 64'd0);
        check("rst_i1_overrun", 64'(g_inst[1].overrun), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic with sparse clk_en gaps on instance 0
        for (int i = 0; i < 2500; i++) begin
            en0    = ($urandom_range(0, 3) != 0);
            strobe = ($urandom_range(0, 49) == 0);
            if (strobe) begin
                left  = 12'($urandom);
                right = 12'($urandom);
            end
            @(negedge clk);
        end
        strobe = 1'b0;
        en0    = 1'b1;
        repeat (700) @(negedge clk);

        check("i0_frames_seen", 64'(g_inst[0].frames >= 25), 64'd1);
        check("i1_frames_seen", 64'(g_inst[1].frames >= 6), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
